// File: rtl/mul_add_seq.sv
// Sequential radix-2 shift-add multiply-accumulate: result = a*b + addend, with valid/ready on both sides.
// Optional early exit when no multiplier bits remain: define MUL_ADD_SEQ_EARLY_TERM_EN.
module mul_add_seq #(
    parameter int M = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    input  logic [M-1:0]   addend,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*M-1:0] result,
    output logic           overflow,
    output logic           busy
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   a_q, a_d;
    logic [M-1:0]   b_q, b_d;
    logic [2*M-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*M-1:0] result_q, result_d;
    logic           overflow_q, overflow_d;
    logic           out_valid_q, out_valid_d;
    logic           last_step;

    // The final step is the one whose result is captured; early exit fires once b_reg >> 1 is empty.
    always_comb begin
`ifdef MUL_ADD_SEQ_EARLY_TERM_EN
        last_step = (cnt_q == CW'(M - 1)) || (b_q[M-1:1] == '0);
`else
        last_step = (cnt_q == CW'(M - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        busy      = (state_q != IDLE);
        out_valid = out_valid_q;
        result    = result_q;
        overflow  = overflow_q;
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    p_d   = {{M{1'b0}}, addend};
                    cnt_d = '0;
                end
            end
            CALC: begin
                if (b_q[0]) begin
                    p_d = p_q + ({{M{1'b0}}, a_q} << cnt_q);
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    result_d    = p_d;
                    overflow_d  = |p_d[2*M-1:M];
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
